qick_dmem_arbiter: RTL and testbench

- Shares one single-port synchronous data memory (TYPE_IF_MEM signal set: en/we/addr/w_dt/r_dt) between two requesters.
- Requester 0 is the processor core; requester 1 is the external AXI/host access path.
- Fixed core priority, with a starvation limiter that guarantees the external side a slot.
- Registered memory command stage plus a tag pipeline that steers read data back to the owner.

---
 rtl/qick_dmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_qick_dmem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qick_dmem_arbiter.sv
// rtl/qick_dmem_arbiter.sv - core/ext arbiter for one single-port data memory (optional QICK_DMEM_ARB_STATS_EN wait counters)
module qick_dmem_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 8,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          core_req_i,
    input  logic          core_we_i,
    input  logic [AW-1:0] core_addr_i,
    input  logic [DW-1:0] core_w_dt_i,
    output logic          core_gnt_o,
    output logic          core_rvalid_o,
    output logic [DW-1:0] core_r_dt_o,
    input  logic          ext_req_i,
    input  logic          ext_we_i,
    input  logic [AW-1:0] ext_addr_i,
    input  logic [DW-1:0] ext_w_dt_i,
    output logic          ext_gnt_o,
    output logic          ext_rvalid_o,
    output logic [DW-1:0] ext_r_dt_o,
    output logic          dmem_en_o,
    output logic          dmem_we_o,
    output logic [AW-1:0] dmem_addr_o,
    output logic [DW-1:0] dmem_w_dt_o,
    input  logic [DW-1:0] dmem_r_dt_i,
`ifdef QICK_DMEM_ARB_STATS_EN
    input  logic          stats_clr_i,
    output logic [31:0]   core_wait_cnt_o,
    output logic [31:0]   ext_wait_cnt_o,
`endif
    output logic          arb_force_o
);

    typedef enum logic {CORE_PRI, EXT_FORCE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  starve_q, starve_d;
    logic        issue_rd;

    // Tag pipeline: index 0 lines up with the command register, index RD_LAT with returning data.
    logic [RD_LAT:0] tag_v_q;
    logic [RD_LAT:0] tag_ext_q;

    // Grant decode, starvation counter next value and next state.
    always_comb begin
        core_gnt_o = 1'b0;
        ext_gnt_o  = 1'b0;
        state_d    = CORE_PRI;
        if (rst_ni) begin
            if (state_q == EXT_FORCE) begin
                ext_gnt_o = ext_req_i;
            end else if (core_req_i) begin
                core_gnt_o = 1'b1;
            end else begin
                ext_gnt_o = ext_req_i;
            end
        end
        starve_d = (ext_req_i && !ext_gnt_o) ? starve_q + 8'd1 : 8'd0;
        // Force the next slot to ext as soon as the denied streak hits the limit.
        if (state_q == CORE_PRI && ext_req_i && !ext_gnt_o && starve_d == 8'(STARVE_MAX)) begin
            state_d = EXT_FORCE;
        end
    end

    assign issue_rd = (core_gnt_o && !core_we_i) || (ext_gnt_o && !ext_we_i);

    // FSM state and starvation counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= CORE_PRI;
            starve_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Command stage: register the granted request; address/data hold when idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dmem_en_o   <= 1'b0;
            dmem_we_o   <= 1'b0;
            dmem_addr_o <= '0;
            dmem_w_dt_o <= '0;
        end else begin
            dmem_en_o <= core_gnt_o | ext_gnt_o;
            if (core_gnt_o) begin
                dmem_we_o   <= core_we_i;
                dmem_addr_o <= core_addr_i;
                dmem_w_dt_o <= core_w_dt_i;
            end else if (ext_gnt_o) begin
                dmem_we_o   <= ext_we_i;
                dmem_addr_o <= ext_addr_i;
                dmem_w_dt_o <= ext_w_dt_i;
            end else begin
                dmem_we_o   <= 1'b0;
            end
        end
    end

    // Read tag shift register; writes enter as invalid slots.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_v_q   <= '0;
            tag_ext_q <= '0;
        end else begin
            tag_v_q   <= {tag_v_q[RD_LAT-1:0], issue_rd};
            tag_ext_q <= {tag_ext_q[RD_LAT-1:0], ext_gnt_o};
        end
    end

    // Read return steering: data is passed through, only the owner sees rvalid.
    always_comb begin
        core_rvalid_o = tag_v_q[RD_LAT] && !tag_ext_q[RD_LAT];
        ext_rvalid_o  = tag_v_q[RD_LAT] &&  tag_ext_q[RD_LAT];
        core_r_dt_o   = rst_ni ? dmem_r_dt_i : '0;
        ext_r_dt_o    = rst_ni ? dmem_r_dt_i : '0;
    end

    assign arb_force_o = (state_q == EXT_FORCE);

`ifdef QICK_DMEM_ARB_STATS_EN
    // Saturating wait-cycle counters; clear wins over increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            core_wait_cnt_o <= 32'd0;
            ext_wait_cnt_o  <= 32'd0;
        end else if (stats_clr_i) begin
            core_wait_cnt_o <= 32'd0;
            ext_wait_cnt_o  <= 32'd0;
        end else begin
            if (core_req_i && !core_gnt_o && core_wait_cnt_o != 32'hFFFF_FFFF) begin
                core_wait_cnt_o <= core_wait_cnt_o + 32'd1;
            end
            if (ext_req_i && !ext_gnt_o && ext_wait_cnt_o != 32'hFFFF_FFFF) begin
                ext_wait_cnt_o <= ext_wait_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_qick_dmem_arbiter.sv
// tb/tb_qick_dmem_arbiter.sv - self-checking bench for qick_dmem_arbiter (RD_LAT=1 and RD_LAT=3 instances)
module tb_qick_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, preload;
    logic        core_req, core_we, ext_req, ext_we;
    logic [7:0]  core_addr, ext_addr;
    logic [31:0] core_w_dt, ext_w_dt;

    logic        c_gnt, c_rv, e_gnt, e_rv, m_en, m_we, force1;
    logic [31:0] c_rdt, e_rdt, m_wdt, m_rdt;
    logic [7:0]  m_addr;
    logic        c_gnt3, c_rv3, e_gnt3, e_rv3, m_en3, m_we3, force3;
    logic [31:0] c_rdt3, e_rdt3, m_wdt3, m_rdt3;
    logic [7:0]  m_addr3;
`ifdef QICK_DMEM_ARB_STATS_EN
    logic        stats_clr;
    logic [31:0] cw1, ew1, cw3, ew3;
`endif

    int nvec = 0;
    int nerr = 0;

    qick_dmem_arbiter #(.DW(32), .AW(8), .RD_LAT(1), .STARVE_MAX(4)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr), .core_w_dt_i(core_w_dt),
        .core_gnt_o(c_gnt), .core_rvalid_o(c_rv), .core_r_dt_o(c_rdt),
        .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_addr_i(ext_addr), .ext_w_dt_i(ext_w_dt),
        .ext_gnt_o(e_gnt), .ext_rvalid_o(e_rv), .ext_r_dt_o(e_rdt),
        .dmem_en_o(m_en), .dmem_we_o(m_we), .dmem_addr_o(m_addr), .dmem_w_dt_o(m_wdt),
        .dmem_r_dt_i(m_rdt),
`ifdef QICK_DMEM_ARB_STATS_EN
        .stats_clr_i(stats_clr), .core_wait_cnt_o(cw1), .ext_wait_cnt_o(ew1),
`endif
        .arb_force_o(force1)
    );

    qick_dmem_arbiter #(.DW(32), .AW(8), .RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr), .core_w_dt_i(core_w_dt),
        .core_gnt_o(c_gnt3), .core_rvalid_o(c_rv3), .core_r_dt_o(c_rdt3),
        .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_addr_i(ext_addr), .ext_w_dt_i(ext_w_dt),
        .ext_gnt_o(e_gnt3), .ext_rvalid_o(e_rv3), .ext_r_dt_o(e_rdt3),
        .dmem_en_o(m_en3), .dmem_we_o(m_we3), .dmem_addr_o(m_addr3), .dmem_w_dt_o(m_wdt3),
        .dmem_r_dt_i(m_rdt3),
`ifdef QICK_DMEM_ARB_STATS_EN
        .stats_clr_i(stats_clr), .core_wait_cnt_o(cw3), .ext_wait_cnt_o(ew3),
`endif
        .arb_force_o(force3)
    );

    function automatic logic [31:0] init_val(input int a);
        return (a == 16) ? 32'h1234_5678 : (32'hC0DE_0000 + 32'(a));
    endfunction

    // Memory models: 1-cycle and 3-cycle read latency single-port RAMs.
    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    logic [31:0] p3a, p3b;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem1[i] <= init_val(i);
        end else if (m_en) begin
            if (m_we) mem1[m_addr] <= m_wdt;
            else      m_rdt <= mem1[m_addr];
        end
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem3[i] <= init_val(i);
        end else begin
            if (m_en3 && m_we3) mem3[m_addr3] <= m_wdt3;
            if (m_en3 && !m_we3) p3a <= mem3[m_addr3];
            p3b    <= p3a;
            m_rdt3 <= p3b;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit cr; bit er; bit cg; bit eg; bit f;
    } vec_t;

    function automatic vec_t mk(input bit cr, input bit er, input bit cg, input bit eg, input bit f);
        vec_t v;
        v.cr = cr; v.er = er; v.cg = cg; v.eg = eg; v.f = f;
        return v;
    endfunction

    vec_t tbl [$];
    vec_t prv1, prv2;

    initial begin
        rst_n = 1'b0; preload = 1'b1;
        core_req = 0; core_we = 0; core_addr = 0; core_w_dt = 0;
        ext_req = 0; ext_we = 0; ext_addr = 0; ext_w_dt = 0;
`ifdef QICK_DMEM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        // Contention table: core wins 4, ext forced once, repeated; then corner patterns.
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 1));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0));

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst core_gnt", c_gnt, 0);
        chk("rst ext_gnt", e_gnt, 0);
        chk("rst dmem_en", m_en, 0);
        chk("rst dmem_we", m_we, 0);
        chk("rst dmem_addr", m_addr, 0);
        chk("rst dmem_w_dt", m_wdt, 0);
        chk("rst core_rvalid", c_rv, 0);
        chk("rst ext_rvalid", e_rv, 0);
        chk("rst arb_force", force1, 0);
        chk("rst dut3 dmem_en", m_en3, 0);
        preload = 1'b0;
        rst_n = 1'b1;
        repeat (3) next_cyc();

        // Table-driven arbitration, command stage and return-owner checks.
        prv1 = mk(0, 0, 0, 0, 0);
        prv2 = prv1;
        core_addr = 8'h10; ext_addr = 8'h11;
        for (int i = 0; i < tbl.size(); i++) begin
            core_req = tbl[i].cr;
            ext_req  = tbl[i].er;
            @(negedge clk);
            chk($sformatf("T%0d core_gnt", i), c_gnt, tbl[i].cg);
            chk($sformatf("T%0d ext_gnt", i), e_gnt, tbl[i].eg);
            chk($sformatf("T%0d arb_force", i), force1, tbl[i].f);
            chk($sformatf("T%0d dmem_en", i), m_en, prv1.cg | prv1.eg);
            if (prv1.cg | prv1.eg)
                chk($sformatf("T%0d dmem_addr", i), m_addr, prv1.cg ? 32'h10 : 32'h11);
            chk($sformatf("T%0d core_rvalid", i), c_rv, prv2.cg);
            chk($sformatf("T%0d ext_rvalid", i), e_rv, prv2.eg);
            prv2 = prv1;
            prv1 = tbl[i];
            next_cyc();
        end
        core_req = 0; ext_req = 0;
        repeat (4) next_cyc();

        // Core read alone.
        core_req = 1; core_we = 0; core_addr = 8'h10;
        @(negedge clk);
        chk("B core_gnt", c_gnt, 1);
        next_cyc(); core_req = 0;
        @(negedge clk);
        chk("B dmem_en", m_en, 1);
        chk("B dmem_we", m_we, 0);
        chk("B dmem_addr", m_addr, 32'h10);
        chk("B core_rvalid early", c_rv, 0);
        next_cyc();
        @(negedge clk);
        chk("B core_rvalid", c_rv, 1);
        chk("B core_r_dt", c_rdt, 32'h1234_5678);
        chk("B ext_rvalid", e_rv, 0);
        next_cyc();
        @(negedge clk);
        chk("B core_rvalid after", c_rv, 0);
        repeat (3) next_cyc();

        // Ext write then core read of the same address.
        ext_req = 1; ext_we = 1; ext_addr = 8'h20; ext_w_dt = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("C ext_gnt", e_gnt, 1);
        next_cyc();
        ext_req = 0; ext_we = 0;
        core_req = 1; core_we = 0; core_addr = 8'h20;
        @(negedge clk);
        chk("C core_gnt", c_gnt, 1);
        chk("C wr dmem_en", m_en, 1);
        chk("C wr dmem_we", m_we, 1);
        chk("C wr dmem_addr", m_addr, 32'h20);
        chk("C wr dmem_w_dt", m_wdt, 32'hDEAD_BEEF);
        next_cyc(); core_req = 0;
        @(negedge clk);
        chk("C rd dmem_we", m_we, 0);
        chk("C rd dmem_addr", m_addr, 32'h20);
        chk("C no ext_rvalid for write", e_rv, 0);
        next_cyc();
        @(negedge clk);
        chk("C core_rvalid", c_rv, 1);
        chk("C core_r_dt", c_rdt, 32'hDEAD_BEEF);
        repeat (4) next_cyc();

        // Interleaved back-to-back reads on both latencies.
        for (int k = 0; k < 8; k++) begin
            core_req = (k == 0 || k == 2); ext_req = (k == 1);
            core_addr = (k == 0) ? 8'h01 : 8'h03; ext_addr = 8'h02;
            @(negedge clk);
            chk($sformatf("D%0d lat1 core_rvalid", k), c_rv, (k == 2 || k == 4));
            chk($sformatf("D%0d lat1 ext_rvalid", k), e_rv, (k == 3));
            chk($sformatf("D%0d lat3 core_rvalid", k), c_rv3, (k == 4 || k == 6));
            chk($sformatf("D%0d lat3 ext_rvalid", k), e_rv3, (k == 5));
            if (k == 2) chk("D lat1 core data 1", c_rdt, init_val(1));
            if (k == 3) chk("D lat1 ext data 2", e_rdt, init_val(2));
            if (k == 4) chk("D lat1 core data 3", c_rdt, init_val(3));
            if (k == 4) chk("D lat3 core data 1", c_rdt3, init_val(1));
            if (k == 5) chk("D lat3 ext data 2", e_rdt3, init_val(2));
            if (k == 6) chk("D lat3 core data 3", c_rdt3, init_val(3));
            next_cyc();
        end

        // Reset in the middle of an outstanding read.
        core_req = 1; core_we = 0; core_addr = 8'h10;
        @(negedge clk);
        chk("E core_gnt", c_gnt, 1);
        next_cyc();
        #1 rst_n = 1'b0;
        #1;
        chk("E async dmem_en", m_en, 0);
        chk("E async dmem_addr", m_addr, 0);
        chk("E gnt masked in reset", c_gnt, 0);
        chk("E dut3 dmem_en", m_en3, 0);
        repeat (2) @(posedge clk);
        #1;
        core_req = 0;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("E%0d no core_rvalid", k), c_rv, 0);
            chk($sformatf("E%0d no lat3 core_rvalid", k), c_rv3, 0);
            next_cyc();
        end
        core_req = 1; core_addr = 8'h10;
        @(negedge clk);
        chk("E2 core_gnt", c_gnt, 1);
        next_cyc(); core_req = 0;
        next_cyc();
        @(negedge clk);
        chk("E2 core_rvalid", c_rv, 1);
        chk("E2 core_r_dt", c_rdt, 32'h1234_5678);
        repeat (4) next_cyc();

`ifdef QICK_DMEM_ARB_STATS_EN
        // Wait-cycle statistics under contention and their clear.
        stats_clr = 1'b1;
        next_cyc();
        stats_clr = 1'b0;
        @(negedge clk);
        chk("F cleared core", cw1, 0);
        core_req = 1; ext_req = 1; core_addr = 8'h10; ext_addr = 8'h11;
        repeat (10) next_cyc();
        core_req = 0; ext_req = 0;
        @(negedge clk);
        chk("F ext_wait_cnt", ew1, 8);
        chk("F core_wait_cnt", cw1, 2);
        chk("F lat3 ext_wait_cnt", ew3, 8);
        next_cyc();
        stats_clr = 1'b1;
        next_cyc();
        stats_clr = 1'b0;
        @(negedge clk);
        chk("F clr ext_wait_cnt", ew1, 0);
        chk("F clr core_wait_cnt", cw1, 0);
        repeat (2) next_cyc();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
